// File: rtl/hazard_interlock_if.sv
// Handshake bundle between the ID/EX pipeline stages and the hazard interlock.
// The pipeline side drives the decode/execute fields; the interlock returns stall, flush and perf signals.
interface hazard_interlock_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_is_mdu;
    logic              id_reads_hilo;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_branch_taken;
    logic              perf_clr;
    logic              pc_write;
    logic              ifid_write;
    logic              flush_ifid;
    logic              flush_idex;
    logic              mdu_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo,
               ex_memread, ex_rd, ex_branch_taken, perf_clr,
        input  pc_write, ifid_write, flush_ifid, flush_idex, mdu_busy, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu, id_reads_hilo,
               ex_memread, ex_rd, ex_branch_taken, perf_clr,
        output pc_write, ifid_write, flush_ifid, flush_idex, mdu_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_interlock.sv
// Stall/flush controller for the 5-stage pipeline: load-use and MDU-busy interlocks,
// taken-branch flushes, and a saturating stall-cycle counter.
//
// state  | meaning
// IDLE   | no multi-cycle mult/div in flight
// BUSY   | mult/div running; cnt counts down the remaining busy cycles to 0
module hazard_interlock #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input logic               clk,
    input logic               rst,
    hazard_interlock_if.slave bus
);
    localparam int LAT_W = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MDU_LAT - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state;
    logic [LAT_W-1:0] cnt;
    logic [CNT_W-1:0] stall_cnt_q;

    logic busy;
    logic lu;
    logic mh;
    logic stall_raw;
    logic stall;
    logic branch;
    logic issue;

    assign busy = (state == S_BUSY);

    assign lu = bus.ex_memread && (bus.ex_rd != REG_AW'(0)) &&
                ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                 (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));
    assign mh = busy && (bus.id_is_mdu || bus.id_reads_hilo);

    // A taken branch discards the ID instruction, so it must never be held.
    assign stall_raw = (lu || mh) && !bus.ex_branch_taken;
    assign stall     = stall_raw && !rst;
    assign branch    = bus.ex_branch_taken && !rst;
    assign issue     = bus.id_is_mdu && !stall_raw && !bus.ex_branch_taken;

    assign bus.pc_write   = !stall;
    assign bus.ifid_write = !stall;
    assign bus.flush_idex = stall || branch;
    assign bus.flush_ifid = branch;
    assign bus.mdu_busy   = busy;
    assign bus.stall_cnt  = stall_cnt_q;

    // Loading MDU_LAT-1 and leaving at terminal count 0 keeps BUSY for MDU_LAT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        state <= S_BUSY;
                        cnt   <= LAT_LOAD;
                    end
                end
                S_BUSY: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.perf_clr) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_interlock.sv
// Bench for hazard_interlock: a per-cycle behavioural model checked at every negedge,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_hazard_interlock;
    localparam int REG_AW  = 5;
    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 16;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_interlock_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    hazard_interlock #(.REG_AW(REG_AW), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int     checks  = 0;
    int     errors  = 0;
    int     busy_left = 0;   // model: remaining MDU busy cycles
    longint m_cnt   = 0;     // model: stall counter
    bit     started = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    function automatic bit exp_stall();
        bit lu;
        bit mh;
        lu = bus.ex_memread && (bus.ex_rd != 0) &&
             ((bus.id_uses_rs && bus.id_rs == bus.ex_rd) ||
              (bus.id_uses_rt && bus.id_rt == bus.ex_rd));
        mh = (busy_left > 0) && (bus.id_is_mdu || bus.id_reads_hilo);
        return (lu || mh) && !bus.ex_branch_taken && !rst;
    endfunction

    always @(posedge clk) begin
        bit st;
        st = exp_stall();
        if (rst) begin
            busy_left = 0;
            m_cnt     = 0;
        end else begin
            if (bus.perf_clr) m_cnt = 0;
            else if (st && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            if (busy_left > 0) busy_left = busy_left - 1;
            else if (bus.id_is_mdu && !st && !bus.ex_branch_taken) busy_left = MDU_LAT;
        end
    end

    always @(negedge clk) begin
        bit st;
        bit br;
        if (started) begin
            st = exp_stall();
            br = bus.ex_branch_taken && !rst;
            chk("pc_write",   bus.pc_write,   !st);
            chk("ifid_write", bus.ifid_write, !st);
            chk("flush_idex", bus.flush_idex, st || br);
            chk("flush_ifid", bus.flush_ifid, br);
            chk("mdu_busy",   bus.mdu_busy,   busy_left > 0);
            chk("stall_cnt",  bus.stall_cnt,  m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.id_is_mdu = 0; bus.id_reads_hilo = 0; bus.ex_memread = 0; bus.ex_rd = '0;
        bus.ex_branch_taken = 0; bus.perf_clr = 0;
    endtask

    task automatic load_use();
        bus.ex_memread = 1; bus.ex_rd = 5'd8; bus.id_rs = 5'd8; bus.id_uses_rs = 1;
    endtask

    initial begin
        idle();
        rst = 1;
        started = 1;
        step();
        step();
        rst = 0;
        #1;
        chk("rst_pc_write", bus.pc_write, 1);
        chk("rst_flush_idex", bus.flush_idex, 0);
        chk("rst_mdu_busy", bus.mdu_busy, 0);
        chk("rst_stall_cnt", bus.stall_cnt, 0);

        load_use();
        #1;
        chk("lu_pc_write", bus.pc_write, 0);
        chk("lu_ifid_write", bus.ifid_write, 0);
        chk("lu_flush_idex", bus.flush_idex, 1);
        step();
        idle();
        #1;
        chk("lu_after_pc_write", bus.pc_write, 1);
        chk("lu_after_flush_idex", bus.flush_idex, 0);
        chk("lu_after_cnt", bus.stall_cnt, 1);

        bus.ex_memread = 1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0; bus.id_uses_rs = 1;
        #1;
        chk("r0_no_stall", bus.pc_write, 1);
        step();
        idle();
        bus.ex_memread = 1; bus.ex_rd = 5'd8; bus.id_rt = 5'd8; bus.id_rs = 5'd3; bus.id_uses_rs = 1;
        #1;
        chk("rt_unused_no_stall", bus.pc_write, 1);
        step();

        idle();
        bus.perf_clr = 1;
        step();
        bus.perf_clr = 0;
        bus.id_is_mdu = 1;
        #1;
        chk("mult_issue_pc_write", bus.pc_write, 1);
        step();
        bus.id_is_mdu = 0;
        bus.id_reads_hilo = 1;
        for (int i = 0; i < MDU_LAT; i++) begin
            #1;
            chk("mflo_busy", bus.mdu_busy, 1);
            chk("mflo_stall", bus.pc_write, 0);
            step();
        end
        #1;
        chk("mflo_go_busy", bus.mdu_busy, 0);
        chk("mflo_go_pc_write", bus.pc_write, 1);
        chk("mflo_stall_cnt", bus.stall_cnt, 4);
        step();

        idle();
        load_use();
        bus.ex_branch_taken = 1;
        #1;
        chk("br_pc_write", bus.pc_write, 1);
        chk("br_flush_ifid", bus.flush_ifid, 1);
        chk("br_flush_idex", bus.flush_idex, 1);
        step();
        idle();
        #1;
        chk("br_cnt_unchanged", bus.stall_cnt, 4);

        load_use();
        repeat (70000) step();
        chk("sat_cnt", bus.stall_cnt, 16'hFFFF);
        bus.perf_clr = 1;
        step();
        idle();
        #1;
        chk("clr_cnt", bus.stall_cnt, 0);

        bus.id_is_mdu = 1;
        step();
        bus.id_is_mdu = 0;
        step();
        chk("pre_rst_busy", bus.mdu_busy, 1);
        rst = 1;
        load_use();
        bus.id_reads_hilo = 1;
        #1;
        chk("in_rst_pc_write", bus.pc_write, 1);
        chk("in_rst_flush_idex", bus.flush_idex, 0);
        chk("in_rst_flush_ifid", bus.flush_ifid, 0);
        step();
        rst = 0;
        idle();
        #1;
        chk("post_rst_busy", bus.mdu_busy, 0);
        chk("post_rst_cnt", bus.stall_cnt, 0);
        chk("post_rst_pc_write", bus.pc_write, 1);

        repeat (3000) begin
            bus.id_rs           = REG_AW'($urandom_range(0, 3));
            bus.id_rt           = REG_AW'($urandom_range(0, 3));
            bus.ex_rd           = REG_AW'($urandom_range(0, 3));
            bus.id_uses_rs      = 1'($urandom_range(0, 1));
            bus.id_uses_rt      = 1'($urandom_range(0, 1));
            bus.ex_memread      = ($urandom_range(0, 2) == 0);
            bus.id_is_mdu       = ($urandom_range(0, 3) == 0);
            bus.id_reads_hilo   = ($urandom_range(0, 3) == 0);
            bus.ex_branch_taken = ($urandom_range(0, 7) == 0);
            bus.perf_clr        = ($urandom_range(0, 31) == 0);
            rst                 = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 0;
        idle();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
